// File: rtl/fc_pkg.sv
// Shared constants and the buffered group type used by the FC core and its output requantizer.
package fc_pkg;
    localparam int ACC_W   = 44;
    localparam int ACT_W   = 4;
    localparam int ACT_MAX = 15;
    localparam int N_LANES = 4;

    typedef logic [ACT_W-1:0] act_t;

    typedef struct packed {
        logic [1:0]              layer;
        act_t [N_LANES-1:0]      act;
    } fc_group_t;
endpackage

// File: rtl/fc_requant_lane.sv
// Single-lane requantizer: ReLU, arithmetic right shift, clamp to the activation range.
module fc_requant_lane
    import fc_pkg::*;
#(
    parameter int ACC_W = fc_pkg::ACC_W,
    parameter int SH_W  = $clog2(fc_pkg::ACC_W)
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [SH_W-1:0]  shift,
    output act_t                    act
);

    function automatic act_t relu_shift_sat(input logic signed [ACC_W-1:0] v,
                                            input logic [SH_W-1:0] sh);
        logic [ACC_W-1:0] t;
        t = v >>> sh;
        if (v[ACC_W-1]) return '0;
        if (t > ACC_W'(ACT_MAX)) return act_t'(ACT_MAX);
        return act_t'(t);
    endfunction

    assign act = relu_shift_sat(acc, shift);

endmodule

// File: rtl/fc_out_requant.sv
// Requantizes FC accumulator groups into 4-bit activations and streams them from a two-group FIFO.
module fc_out_requant
    import fc_pkg::*;
#(
    parameter int ACC_W  = fc_pkg::ACC_W,
    parameter int ACT_W  = fc_pkg::ACT_W,
    parameter int SHIFT0 = 6,
    parameter int SHIFT1 = 6,
    parameter int SHIFT2 = 6,
    parameter int SHIFT3 = 0
) (
    input  logic                    clk,
    input  logic                    rst_fsm,
    input  logic                    acc_valid,
    input  logic        [1:0]       layer_fc,
    input  logic signed [ACC_W-1:0] o_data1,
    input  logic signed [ACC_W-1:0] o_data2,
    input  logic signed [ACC_W-1:0] o_data3,
    input  logic signed [ACC_W-1:0] o_data4,
    output logic        [ACT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic        [1:0]       out_layer,
    output logic                    overflow,
    output logic                    busy
);

    localparam int SH_W = $clog2(ACC_W);

    typedef enum logic {S_IDLE, S_STREAM} state_e;

    state_e                  state_q, state_d;
    logic                    wp_q, wp_d;
    logic                    rp_q, rp_d;
    logic [1:0]              count_q, count_d;
    logic [1:0]              beat_q, beat_d;
    logic                    overflow_q, overflow_d;
    fc_group_t               mem_q [2];
    fc_group_t               entry_d;
    fc_group_t               head;

    logic signed [ACC_W-1:0] acc_lane [N_LANES];
    act_t                    lane_act [N_LANES];
    logic [SH_W-1:0]         shift_sel;

    logic                    hs;
    logic                    last_hs;
    logic                    space;
    logic                    cap;

    assign acc_lane[0] = o_data1;
    assign acc_lane[1] = o_data2;
    assign acc_lane[2] = o_data3;
    assign acc_lane[3] = o_data4;

    always_comb begin
        shift_sel = SH_W'(SHIFT0);
        case (layer_fc)
            2'd1:    shift_sel = SH_W'(SHIFT1);
            2'd2:    shift_sel = SH_W'(SHIFT2);
            2'd3:    shift_sel = SH_W'(SHIFT3);
            default: shift_sel = SH_W'(SHIFT0);
        endcase
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        fc_requant_lane #(.ACC_W(ACC_W), .SH_W(SH_W)) u_lane (
            .acc   (acc_lane[i]),
            .shift (shift_sel),
            .act   (lane_act[i])
        );
    end

    always_comb begin
        entry_d.layer = layer_fc;
        for (int i = 0; i < N_LANES; i++) entry_d.act[i] = lane_act[i];
    end

    // A full buffer can still accept a group when its head drains on this very edge.
    always_comb begin
        hs         = (state_q == S_STREAM) && out_ready;
        last_hs    = hs && (beat_q == 2'd3);
        space      = (count_q != 2'd2) || last_hs;
        cap        = acc_valid && space;

        beat_d     = hs ? beat_q + 2'd1 : beat_q;
        rp_d       = last_hs ? ~rp_q : rp_q;
        wp_d       = cap ? ~wp_q : wp_q;
        overflow_d = overflow_q || (acc_valid && !space);

        count_d = count_q;
        if (cap && !last_hs)      count_d = count_q + 2'd1;
        else if (!cap && last_hs) count_d = count_q - 2'd1;

        state_d = (count_d == 2'd0) ? S_IDLE : S_STREAM;
    end

    always_ff @(posedge clk or negedge rst_fsm) begin
        if (!rst_fsm) begin
            state_q    <= S_IDLE;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            count_q    <= 2'd0;
            beat_q     <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (cap) mem_q[wp_q] <= entry_d;
    end

    assign head      = mem_q[rp_q];
    assign out_valid = (state_q == S_STREAM);
    assign out_data  = out_valid ? head.act[beat_q] : '0;
    assign out_last  = out_valid && (beat_q == 2'd3);
    assign out_layer = out_valid ? head.layer : 2'd0;
    assign overflow  = overflow_q;
    assign busy      = (count_q != 2'd0);

endmodule

// File: tb/tb_fc_out_requant.sv
// Scoreboard bench for fc_out_requant: group-level reference model feeds an expected-beat queue.
module tb_fc_out_requant;

    logic               clk = 1'b0;
    logic               rst_fsm = 1'b0;
    logic               acc_valid = 1'b0;
    logic [1:0]         layer_fc = 2'd0;
    logic signed [43:0] o_data1 = '0, o_data2 = '0, o_data3 = '0, o_data4 = '0;
    logic [3:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               out_last;
    logic [1:0]         out_layer;
    logic               overflow;
    logic               busy;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [3:0] data;
        logic       last;
        logic [1:0] layer;
    } beat_t;

    beat_t exp_q[$];
    int    beats_held = 0;
    logic  ov_exp = 1'b0;
    int    shift_of[4] = '{6, 6, 6, 0};

    fc_out_requant dut (
        .clk       (clk),
        .rst_fsm   (rst_fsm),
        .acc_valid (acc_valid),
        .layer_fc  (layer_fc),
        .o_data1   (o_data1),
        .o_data2   (o_data2),
        .o_data3   (o_data3),
        .o_data4   (o_data4),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_layer (out_layer),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: ReLU, then shift, then clamp to 15, computed in 64-bit signed arithmetic.
    function automatic logic [3:0] ref_act(input logic [43:0] a, input int sh);
        longint signed v;
        v = {{20{a[43]}}, a};
        if (v < 0) return 4'd0;
        v = v >>> sh;
        return (v > 15) ? 4'd15 : v[3:0];
    endfunction

    // Reference model: tracks buffered beats at group granularity and predicts acceptance.
    always @(posedge clk) begin
        if (!rst_fsm) begin
            exp_q.delete();
            beats_held = 0;
            ov_exp     = 1'b0;
        end else begin
            bit hs_m, last_m, accept;
            int groups;
            logic [43:0] lanes[4];
            hs_m   = (beats_held > 0) && out_ready;
            last_m = hs_m && (beats_held % 4 == 1);
            groups = (beats_held + 3) / 4;
            accept = acc_valid && (groups < 2 || last_m);
            if (hs_m) beats_held--;
            if (accept) begin
                lanes = '{o_data1, o_data2, o_data3, o_data4};
                for (int i = 0; i < 4; i++) begin
                    beat_t b;
                    b.data  = ref_act(lanes[i], shift_of[layer_fc]);
                    b.last  = (i == 3);
                    b.layer = layer_fc;
                    exp_q.push_back(b);
                end
                beats_held += 4;
            end else if (acc_valid) begin
                ov_exp = 1'b1;
            end
        end
    end

    // Monitor: samples mid-cycle; the front beat must be presented (and held) until accepted.
    always @(negedge clk) begin
        if (rst_fsm) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("overflow", overflow, ov_exp);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_last", out_last, exp_q[0].last);
                chk("out_layer", out_layer, exp_q[0].layer);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] layer, input logic [43:0] d1, input logic [43:0] d2,
                        input logic [43:0] d3, input logic [43:0] d4);
        acc_valid = 1'b1;
        layer_fc  = layer;
        o_data1 = d1; o_data2 = d2; o_data3 = d3; o_data4 = d4;
        cycle();
        acc_valid = 1'b0;
    endtask

    function automatic logic [43:0] rnd_acc(input int sh);
        case ($urandom_range(0, 4))
            0: return 44'($urandom_range(0, 17 << sh));
            1: return -44'($urandom_range(1, 100000));
            2: return {12'($urandom), 32'($urandom)};
            3: return 44'($urandom_range(0, 1000));
            default: return ($urandom_range(0, 1) != 0) ? 44'h7FF_FFFF_FFFF : 44'h800_0000_0000;
        endcase
    endfunction

    task automatic send_rnd();
        logic [1:0] l;
        l = 2'($urandom_range(0, 3));
        send(l, rnd_acc(shift_of[l]), rnd_acc(shift_of[l]), rnd_acc(shift_of[l]), rnd_acc(shift_of[l]));
    endtask

    initial begin
        logic [43:0] big;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_layer", out_layer, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_fsm = 1'b1;
        cycle();

        // Single group, full-rate sink.
        out_ready = 1'b1;
        send(2'd0, 44'd64, 44'd100, -44'sd5, 44'd2000);
        chk("latency_valid", out_valid, 1);
        chk("first_beat", out_data, 4'd1);
        repeat (6) cycle();

        // Pass-through layer with saturation.
        big = 44'h7FF_FFFF_FFFF;
        send(2'd3, 44'd7, 44'd15, 44'd16, big);
        repeat (6) cycle();

        // Backpressure on the first beat.
        out_ready = 1'b0;
        send(2'd1, 44'd1000, 44'd500, 44'd64, 44'd63);
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("busy_after_drain", busy, 0);

        // Three back-to-back groups into a stalled sink: third is dropped.
        out_ready = 1'b0;
        send(2'd0, 44'd640, 44'd320, 44'd128, 44'd64);
        send(2'd1, 44'd192, 44'd256, 44'd0, 44'd960);
        send(2'd2, 44'd100, 44'd200, 44'd300, 44'd400);
        chk("overflow_set", overflow, 1);
        repeat (2) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();
        // Group D arrives on the same edge as the head's final beat.
        send(2'd3, 44'd3, 44'd9, 44'd12, 44'd1);
        repeat (12) cycle();
        chk("overflow_sticky", overflow, 1);

        // Asynchronous reset after two beats.
        send(2'd2, 44'd320, 44'd640, 44'd960, 44'd64);
        repeat (2) cycle();
        #2;
        rst_fsm = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        rst_fsm = 1'b1;
        cycle();
        send(2'd1, 44'd128, 44'd1, 44'd900, -44'sd1);
        repeat (6) cycle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) send_rnd();
            else cycle();
        end

        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
        chk("drain_timeout", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
